windrec2pol_sched: RTL and testbench
====================================

Name: windrec2pol_sched

Overview:
- Scheduler that time-shares one windrec2pol rectangular-to-polar converter between N_CH wind-sensor channels.
- Arbitrates pending (xspeed, yspeed) samples round-robin and issues a one-cycle data_rdy to the converter.
- Enforces the converter's minimum issue spacing and waits its fixed latency.
- Returns speed/direction tagged with the channel ID. Sits between the per-axis sensor front-ends and the output/logging stage.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- CH_W, 2, channel ID width, equal to clog2(N_CH).
- LATENCY, 18, cycles from converter data_rdy to valid speed/direction; must be at least 1.
- CADENCE, 20, minimum cycles between successive data_rdy pulses; must be at least LATENCY+2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- chan_en  in  N_CH  per-channel enable mask; masked channels are never granted.
- req_valid  in  N_CH  channel i has a sample pending.
- req_x  in  N_CH*16  flattened x speeds, channel i at bits [16i+15:16i], Q5.10 signed.
- req_y  in  N_CH*16  flattened y speeds, same layout.
- req_ack  out  N_CH  one-hot, one-cycle pulse: channel's sample consumed.
- cv_data_rdy  out  1  to windrec2pol data_rdy.
- cv_xspeed  out  16  to windrec2pol xspeed.
- cv_yspeed  out  16  to windrec2pol yspeed.
- cv_speed  in  16  from windrec2pol speed.
- cv_direction  in  16  from windrec2pol direction.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  CH_W  channel ID of the result.
- res_speed  out  16  captured speed.
- res_direction  out  16  captured direction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): applies on the next rising edge.
  - State goes to IDLE.
  - All outputs return to 0.
  - Spacing counter = 0, so an immediate issue is allowed.
  - last_grant = N_CH-1, so channel 0 has highest priority first.
  - An in-flight conversion is abandoned; no res_valid is produced for it.
- All outputs are registered.
- State IDLE:
  - Eligible set = req_valid & chan_en.
  - If the eligible set is non-zero and the spacing counter is 0, grant the first eligible channel searching upward from last_grant+1 (mod N_CH).
  - At that edge, register cv_xspeed/cv_yspeed from the granted slice, set cv_data_rdy, set req_ack[g], latch g into ch_reg and last_grant, load spacing = CADENCE-1, and go to ISSUE.
- State ISSUE (1 cycle):
  - cv_data_rdy = 1 and req_ack[g] = 1 for exactly this cycle.
  - Load wait counter = LATENCY-1, then go to WAIT.
  - cv_xspeed/cv_yspeed hold until the next grant.
- State WAIT:
  - Decrement the wait counter each cycle.
  - On the edge where it is 0: capture cv_speed and cv_direction into res_speed/res_direction, res_ch = ch_reg, res_valid <= 1, go to DONE.
- State DONE (1 cycle): res_valid = 1, then go to IDLE.
  - res_speed, res_direction and res_ch hold until the next capture.
- Result timing: if data_rdy is high in cycle I, res_valid is high in cycle I+LATENCY+1.
- Spacing counter:
  - Free-running decrement while non-zero, in all states.
  - Consecutive data_rdy pulses are therefore at least CADENCE cycles apart.
  - With a back-to-back load, pulses are exactly CADENCE apart.
- Handshake:
  - The requester holds req_valid and its data stable until it sees req_ack.
  - Data is sampled at the grant edge, so the requester may change data on the edge ending its ack cycle.
  - If req_valid is still high after ack, it is treated as a new sample.
- Boundary cases:
  - A channel whose req_valid is removed before grant is simply skipped.
  - Clearing chan_en mid-conversion does not abort the conversion; it only affects later grants.
  - With all channels requesting continuously, grants rotate 0,1,...,N_CH-1,0 with one grant per CADENCE cycles; no starvation.
  - A single requester gets every slot.
- Arithmetic: no datapath arithmetic. Counters are clog2(CADENCE) bits wide and saturate at 0.

Decomposition:
- Shared package/header windrec_pkg:
  - state encodings IDLE, ISSUE, WAIT, DONE;
  - default LATENCY and CADENCE constants;
  - the Q5.10 format width.
- One natural sub-module: rr_arbiter (N_CH requests in, last_grant in, one-hot grant out plus any_grant; combinational).
- The FSM and counters stay in windrec2pol_sched.

Test Plan:
- Bench setup: a behavioural windrec2pol stub gives speed = x+y and direction = x-y, valid exactly LATENCY cycles after data_rdy.
- Test 1: after reset, ch2 requests x=0x0400, y=0x0200.
  - cv_data_rdy is high in cycle I, with req_ack = 0100.
  - res_valid is high in cycle I+19 with res_ch=2, res_speed=0x0600, res_direction=0x0200.
- Test 2: all 4 channels request continuously.
  - Grants occur in order 0,1,2,3,0.
  - data_rdy pulses are exactly 20 cycles apart.
  - Each channel gets exactly one ack per 80 cycles.
- Test 3: chan_en=1011 with all requesting.
  - Channel 2 is never acked.
  - Grant order is 0,1,3,0.
- Test 4: reset asserted 5 cycles after data_rdy.
  - No res_valid follows.
  - busy=0 and all outputs are 0 the cycle after reset.
  - The next request is granted to the lowest eligible channel.
- Test 5: ch1 drops req_valid before its turn while ch0 and ch3 request.
  - Grant sequence is 0,3.
  - req_ack[1] is never pulsed.
- Test 6: ch0 requests alone; a second sample arrives 2 cycles after ack.
  - The second data_rdy fires exactly 20 cycles after the first, not earlier.

Source files
------------

// File: rtl/windrec_pkg.sv
// rtl/windrec_pkg.sv - shared states, defaults and sample width for the windrec2pol scheduler
package windrec_pkg;
    localparam int Q_W         = 16;
    localparam int DEF_LATENCY = 18;
    localparam int DEF_CADENCE = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } sched_state_t;
endpackage

// File: rtl/windrec2pol_sched_rr_arbiter.sv
// rtl/windrec2pol_sched_rr_arbiter.sv - combinational round-robin arbiter, searches upward from last_grant+1
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] last_grant_i,
    output logic [N_CH-1:0] grant_o,
    output logic            any_grant_o
);
    always_comb begin
        int   idx;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_grant_i) + k) % N_CH;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
        any_grant_o = found;
    end
endmodule

// File: rtl/windrec2pol_sched.sv
// rtl/windrec2pol_sched.sv - time-shares one windrec2pol converter between N_CH channels
module windrec2pol_sched
    import windrec_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CADENCE = DEF_CADENCE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_CH-1:0]       chan_en,
    input  logic [N_CH-1:0]       req_valid,
    input  logic [N_CH*Q_W-1:0]   req_x,
    input  logic [N_CH*Q_W-1:0]   req_y,
    output logic [N_CH-1:0]       req_ack,
    output logic                  cv_data_rdy,
    output logic [Q_W-1:0]        cv_xspeed,
    output logic [Q_W-1:0]        cv_yspeed,
    input  logic [Q_W-1:0]        cv_speed,
    input  logic [Q_W-1:0]        cv_direction,
    output logic                  res_valid,
    output logic [CH_W-1:0]       res_ch,
    output logic [Q_W-1:0]        res_speed,
    output logic [Q_W-1:0]        res_direction,
    output logic                  busy
);
    localparam int CNT_W = $clog2(CADENCE);
    localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(CADENCE - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(LATENCY - 1);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] spacing_q, spacing_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CH_W-1:0]  last_grant_q, last_grant_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [N_CH-1:0]  req_ack_q, req_ack_d;
    logic             cv_data_rdy_q, cv_data_rdy_d;
    logic [Q_W-1:0]   cv_xspeed_q, cv_xspeed_d;
    logic [Q_W-1:0]   cv_yspeed_q, cv_yspeed_d;
    logic             res_valid_q, res_valid_d;
    logic [CH_W-1:0]  res_ch_q, res_ch_d;
    logic [Q_W-1:0]   res_speed_q, res_speed_d;
    logic [Q_W-1:0]   res_direction_q, res_direction_d;
    logic             busy_q, busy_d;

    logic [N_CH-1:0]  grant;
    logic             any_grant;
    logic [CH_W-1:0]  gidx;

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req_i        (req_valid & chan_en),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .any_grant_o  (any_grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) gidx = CH_W'(i);
        end
    end

    always_comb begin
        state_d         = state_q;
        spacing_d       = (spacing_q != '0) ? spacing_q - 1'b1 : '0;
        wait_d          = wait_q;
        last_grant_d    = last_grant_q;
        ch_d            = ch_q;
        req_ack_d       = '0;
        cv_data_rdy_d   = 1'b0;
        cv_xspeed_d     = cv_xspeed_q;
        cv_yspeed_d     = cv_yspeed_q;
        res_valid_d     = 1'b0;
        res_ch_d        = res_ch_q;
        res_speed_d     = res_speed_q;
        res_direction_d = res_direction_q;

        case (state_q)
            // DONE also arbitrates so that back-to-back issues land exactly CADENCE apart.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (any_grant && spacing_q == '0) begin
                    cv_xspeed_d   = req_x[Q_W*gidx +: Q_W];
                    cv_yspeed_d   = req_y[Q_W*gidx +: Q_W];
                    cv_data_rdy_d = 1'b1;
                    req_ack_d     = grant;
                    ch_d          = gidx;
                    last_grant_d  = gidx;
                    spacing_d     = SPACE_LOAD;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    res_speed_d     = cv_speed;
                    res_direction_d = cv_direction;
                    res_ch_d        = ch_q;
                    res_valid_d     = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            spacing_q       <= '0;
            wait_q          <= '0;
            last_grant_q    <= CH_W'(N_CH - 1);
            ch_q            <= '0;
            req_ack_q       <= '0;
            cv_data_rdy_q   <= 1'b0;
            cv_xspeed_q     <= '0;
            cv_yspeed_q     <= '0;
            res_valid_q     <= 1'b0;
            res_ch_q        <= '0;
            res_speed_q     <= '0;
            res_direction_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            spacing_q       <= spacing_d;
            wait_q          <= wait_d;
            last_grant_q    <= last_grant_d;
            ch_q            <= ch_d;
            req_ack_q       <= req_ack_d;
            cv_data_rdy_q   <= cv_data_rdy_d;
            cv_xspeed_q     <= cv_xspeed_d;
            cv_yspeed_q     <= cv_yspeed_d;
            res_valid_q     <= res_valid_d;
            res_ch_q        <= res_ch_d;
            res_speed_q     <= res_speed_d;
            res_direction_q <= res_direction_d;
            busy_q          <= busy_d;
        end
    end

    assign req_ack       = req_ack_q;
    assign cv_data_rdy   = cv_data_rdy_q;
    assign cv_xspeed     = cv_xspeed_q;
    assign cv_yspeed     = cv_yspeed_q;
    assign res_valid     = res_valid_q;
    assign res_ch        = res_ch_q;
    assign res_speed     = res_speed_q;
    assign res_direction = res_direction_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_windrec2pol_sched.sv
// tb/tb_windrec2pol_sched.sv - self-checking bench for windrec2pol_sched with a converter stub
module tb_windrec2pol_sched;
    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int LATENCY = 18;
    localparam int CADENCE = 20;

    logic               clock = 1'b0;
    logic               reset;
    logic [N_CH-1:0]    chan_en;
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*16-1:0] req_x;
    logic [N_CH*16-1:0] req_y;
    logic [N_CH-1:0]    req_ack;
    logic               cv_data_rdy;
    logic [15:0]        cv_xspeed, cv_yspeed, cv_speed, cv_direction;
    logic               res_valid;
    logic [CH_W-1:0]    res_ch;
    logic [15:0]        res_speed, res_direction;
    logic               busy;

    always #5 clock = ~clock;

    windrec2pol_sched #(.N_CH(N_CH), .CH_W(CH_W), .LATENCY(LATENCY), .CADENCE(CADENCE)) dut (
        .clock(clock), .reset(reset), .chan_en(chan_en), .req_valid(req_valid),
        .req_x(req_x), .req_y(req_y), .req_ack(req_ack), .cv_data_rdy(cv_data_rdy),
        .cv_xspeed(cv_xspeed), .cv_yspeed(cv_yspeed), .cv_speed(cv_speed),
        .cv_direction(cv_direction), .res_valid(res_valid), .res_ch(res_ch),
        .res_speed(res_speed), .res_direction(res_direction), .busy(busy)
    );

    // Converter stub: speed = x+y, direction = x-y, valid only in the cycle LATENCY after data_rdy.
    logic [LATENCY-1:0] hist = '0;
    logic [15:0]        sx = '0, sy = '0;
    always @(posedge clock) begin
        hist <= {hist[LATENCY-2:0], cv_data_rdy};
        if (cv_data_rdy) begin
            sx <= cv_xspeed;
            sy <= cv_yspeed;
        end
    end
    assign cv_speed     = hist[LATENCY-1] ? 16'(sx + sy) : 16'hDEAD;
    assign cv_direction = hist[LATENCY-1] ? 16'(sx - sy) : 16'hBEEF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Behavioural model: an issue may happen whenever a channel is eligible and CADENCE cycles
    // have elapsed since the previous one; its result appears LATENCY+1 cycles after the issue.
    int          t = 0;
    bit          model_live = 1'b0;
    int          last_issue = -1000;
    bit          pending = 1'b0;
    int          pend_due, pend_ch;
    logic [15:0] pend_x, pend_y;
    int          rr = N_CH - 1;
    logic        exp_rdy = 1'b0, exp_rv = 1'b0, exp_busy = 1'b0;
    logic [3:0]  exp_ack = '0;
    logic [15:0] exp_x = '0, exp_y = '0, exp_spd = '0, exp_dir = '0;
    logic [1:0]  exp_ch = '0;

    always @(posedge clock) begin
        logic [3:0] elig;
        int g;
        t++;
        model_live = 1'b1;
        exp_rdy = 1'b0;
        exp_ack = '0;
        exp_rv  = 1'b0;
        if (reset) begin
            last_issue = -1000;
            pending = 1'b0;
            rr = N_CH - 1;
            exp_x = '0; exp_y = '0; exp_spd = '0; exp_dir = '0; exp_ch = '0; exp_busy = 1'b0;
        end else begin
            if (pending && t == pend_due) begin
                exp_rv  = 1'b1;
                exp_ch  = 2'(pend_ch);
                exp_spd = 16'(pend_x + pend_y);
                exp_dir = 16'(pend_x - pend_y);
                pending = 1'b0;
            end
            elig = req_valid & chan_en;
            if (elig != 0 && t - last_issue >= CADENCE) begin
                g = -1;
                for (int k = 1; k <= N_CH; k++)
                    if (g < 0 && elig[(rr + k) % N_CH]) g = (rr + k) % N_CH;
                exp_rdy    = 1'b1;
                exp_ack    = 4'(1 << g);
                exp_x      = req_x[16*g +: 16];
                exp_y      = req_y[16*g +: 16];
                pend_x     = exp_x;
                pend_y     = exp_y;
                pend_ch    = g;
                pend_due   = t + LATENCY + 1;
                pending    = 1'b1;
                last_issue = t;
                rr         = g;
            end
            exp_busy = (t - last_issue) <= LATENCY + 1;
        end
    end

    int          rdy_cyc[$], ack_ch[$], ack_vec[$], res_cyc[$], res_chq[$];
    logic [15:0] res_spq[$], res_dq[$];

    always @(negedge clock) begin
        if (model_live) begin
            chk("cv_data_rdy", cv_data_rdy, exp_rdy);
            chk("req_ack", req_ack, exp_ack);
            chk("cv_xspeed", cv_xspeed, exp_x);
            chk("cv_yspeed", cv_yspeed, exp_y);
            chk("res_valid", res_valid, exp_rv);
            chk("res_ch", res_ch, exp_ch);
            chk("res_speed", res_speed, exp_spd);
            chk("res_direction", res_direction, exp_dir);
            chk("busy", busy, exp_busy);
            if (cv_data_rdy) rdy_cyc.push_back(t);
            if (req_ack != 0) begin
                ack_vec.push_back(int'(req_ack));
                for (int i = 0; i < N_CH; i++) if (req_ack[i]) ack_ch.push_back(i);
            end
            if (res_valid) begin
                res_cyc.push_back(t);
                res_chq.push_back(int'(res_ch));
                res_spq.push_back(res_speed);
                res_dq.push_back(res_direction);
            end
        end
    end

    task automatic clear_logs;
        rdy_cyc.delete(); ack_ch.delete(); ack_vec.delete();
        res_cyc.delete(); res_chq.delete(); res_spq.delete(); res_dq.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        req_valid = '0;
        chan_en = 4'hF;
        @(negedge clock);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic set_ch(input int ch, input logic [15:0] x, input logic [15:0] y);
        req_x[16*ch +: 16] = x;
        req_y[16*ch +: 16] = y;
    endtask

    // Returns at the negedge of the n-th data_rdy cycle seen from now (the ack cycle).
    task automatic wait_rdy(input int n, input string name);
        int cnt = 0;
        for (int i = 0; i < 300 && cnt < n; i++) begin
            @(negedge clock);
            if (cv_data_rdy) cnt++;
        end
        chk({name, "_rdy_seen"}, cnt, n);
    endtask

    initial begin
        int cnt;
        int orv;
        reset = 1'b1;
        chan_en = 4'hF;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        cycles(3);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ack", req_ack, 0);
        chk("rst_rdy", cv_data_rdy, 0);

        // Test 1: single request on channel 2
        do_reset();
        set_ch(2, 16'h0400, 16'h0200);
        req_valid = 4'b0100;
        wait_rdy(1, "t1");
        req_valid = '0;
        cycles(25);
        chk("t1_nrdy", rdy_cyc.size(), 1);
        chk("t1_nres", res_cyc.size(), 1);
        if (rdy_cyc.size() == 1 && res_cyc.size() == 1) begin
            chk("t1_ackvec", ack_vec[0], 4'b0100);
            chk("t1_latency", res_cyc[0] - rdy_cyc[0], 19);
            chk("t1_res_ch", res_chq[0], 2);
            chk("t1_res_speed", res_spq[0], 16'h0600);
            chk("t1_res_dir", res_dq[0], 16'h0200);
        end

        // Test 2: all channels requesting continuously
        do_reset();
        for (int i = 0; i < N_CH; i++) set_ch(i, 16'(256 * (i + 1)), 16'(16 * (i + 1)));
        req_valid = 4'hF;
        wait_rdy(5, "t2");
        req_valid = '0;
        cycles(25);
        chk("t2_nrdy", rdy_cyc.size(), 5);
        if (rdy_cyc.size() == 5 && ack_ch.size() == 5) begin
            chk("t2_g0", ack_ch[0], 0);
            chk("t2_g1", ack_ch[1], 1);
            chk("t2_g2", ack_ch[2], 2);
            chk("t2_g3", ack_ch[3], 3);
            chk("t2_g4", ack_ch[4], 0);
            for (int i = 1; i < 5; i++) chk("t2_spacing", rdy_cyc[i] - rdy_cyc[i-1], 20);
            for (int c = 0; c < N_CH; c++) begin
                cnt = 0;
                for (int i = 0; i < 5; i++) if (rdy_cyc[i] < rdy_cyc[0] + 80 && ack_ch[i] == c) cnt++;
                chk("t2_per80", cnt, 1);
            end
        end
        if (res_spq.size() >= 1) chk("t2_res0_speed", res_spq[0], 16'h0110);

        // Test 3: channel 2 masked
        do_reset();
        chan_en = 4'b1011;
        req_valid = 4'hF;
        wait_rdy(4, "t3");
        req_valid = '0;
        cycles(25);
        chan_en = 4'hF;
        chk("t3_nack", ack_ch.size(), 4);
        if (ack_ch.size() == 4) begin
            chk("t3_g0", ack_ch[0], 0);
            chk("t3_g1", ack_ch[1], 1);
            chk("t3_g2", ack_ch[2], 3);
            chk("t3_g3", ack_ch[3], 0);
        end

        // Test 4: reset five cycles after data_rdy abandons the conversion
        do_reset();
        set_ch(1, 16'h0123, 16'h0045);
        req_valid = 4'b0010;
        wait_rdy(1, "t4a");
        req_valid = '0;
        cycles(4);
        reset = 1'b1;
        @(negedge clock);
        chk("t4_busy", busy, 0);
        chk("t4_xspeed", cv_xspeed, 0);
        chk("t4_rdy", cv_data_rdy, 0);
        chk("t4_ack", req_ack, 0);
        reset = 1'b0;
        clear_logs();
        cycles(25);
        chk("t4_no_res", res_cyc.size(), 0);
        set_ch(3, 16'h0300, 16'h0100);
        req_valid = 4'b1010;
        wait_rdy(1, "t4b");
        req_valid = '0;
        cycles(25);
        chk("t4_nack", ack_ch.size(), 1);
        if (ack_ch.size() == 1) chk("t4_lowest", ack_ch[0], 1);

        // Test 5: channel 1 withdraws before its turn
        do_reset();
        for (int i = 0; i < N_CH; i++) set_ch(i, 16'(100 + i), 16'(7 * i));
        req_valid = 4'b1011;
        wait_rdy(1, "t5a");
        req_valid = 4'b1000;
        wait_rdy(1, "t5b");
        req_valid = '0;
        cycles(25);
        chk("t5_nack", ack_ch.size(), 2);
        if (ack_ch.size() == 2) begin
            chk("t5_g0", ack_ch[0], 0);
            chk("t5_g1", ack_ch[1], 3);
        end
        orv = 0;
        foreach (ack_vec[i]) orv |= ack_vec[i];
        chk("t5_no_ack1", orv & 2, 0);

        // Test 6: second sample two cycles after ack waits for the full cadence
        do_reset();
        set_ch(0, 16'h0011, 16'h0022);
        req_valid = 4'b0001;
        wait_rdy(1, "t6a");
        req_valid = '0;
        cycles(2);
        set_ch(0, 16'h0033, 16'h0044);
        req_valid = 4'b0001;
        wait_rdy(1, "t6b");
        req_valid = '0;
        cycles(25);
        chk("t6_nrdy", rdy_cyc.size(), 2);
        if (rdy_cyc.size() == 2) chk("t6_spacing", rdy_cyc[1] - rdy_cyc[0], 20);
        if (res_spq.size() == 2) chk("t6_res1_speed", res_spq[1], 16'h0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
